// File: rtl/alu_share_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arb_pkg
// Description : Shared ALU control codes, FSM encoding and legal-code check.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_share_arb_pkg;

    typedef logic [3:0] alu_ctrl_t;

    localparam alu_ctrl_t C_ALU_AND  = 4'b0000;
    localparam alu_ctrl_t C_ALU_OR   = 4'b0001;
    localparam alu_ctrl_t C_ALU_ADD  = 4'b0010;
    localparam alu_ctrl_t C_ALU_0011 = 4'b0011;
    localparam alu_ctrl_t C_ALU_SUB  = 4'b0110;
    localparam alu_ctrl_t C_ALU_SLT  = 4'b0111;
    localparam alu_ctrl_t C_ALU_1001 = 4'b1001;
    localparam alu_ctrl_t C_ALU_LUI  = 4'b1011;
    localparam alu_ctrl_t C_ALU_SRA  = 4'b1110;
    localparam alu_ctrl_t C_ALU_SRAV = 4'b1111;

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_EXEC = 2'd1;
    localparam logic [1:0] C_RESP = 2'd2;

    function automatic logic is_legal_ctrl(input alu_ctrl_t ctrl);
        case (ctrl)
            C_ALU_AND, C_ALU_OR, C_ALU_ADD, C_ALU_0011, C_ALU_SUB,
            C_ALU_SLT, C_ALU_1001, C_ALU_LUI, C_ALU_SRA, C_ALU_SRAV:
                is_legal_ctrl = 1'b1;
            default:
                is_legal_ctrl = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_share_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arb_if
// Description : Request, ALU and response channels of the shared-ALU arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_share_arb_if #(
    parameter int WIDTH = 32
) ();

    logic             req0_valid_i;
    logic             req0_ready_o;
    logic [3:0]       req0_ctrl_i;
    logic [WIDTH-1:0] req0_a_i;
    logic [WIDTH-1:0] req0_b_i;

    logic             req1_valid_i;
    logic             req1_ready_o;
    logic [3:0]       req1_ctrl_i;
    logic [WIDTH-1:0] req1_a_i;
    logic [WIDTH-1:0] req1_b_i;

    logic [3:0]       alu_ctrl_o;
    logic [WIDTH-1:0] alu_src1_o;
    logic [WIDTH-1:0] alu_src2_o;
    logic [WIDTH-1:0] alu_result_i;
    logic             alu_zero_i;

    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic             rsp_id_o;
    logic [WIDTH-1:0] rsp_result_o;
    logic             rsp_zero_o;
    logic             rsp_err_o;

    modport master (
        output req0_valid_i, req0_ctrl_i, req0_a_i, req0_b_i,
        input  req0_ready_o,
        output req1_valid_i, req1_ctrl_i, req1_a_i, req1_b_i,
        input  req1_ready_o,
        input  alu_ctrl_o, alu_src1_o, alu_src2_o,
        output alu_result_i, alu_zero_i,
        input  rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o, rsp_err_o,
        output rsp_ready_i
    );

    modport slave (
        input  req0_valid_i, req0_ctrl_i, req0_a_i, req0_b_i,
        output req0_ready_o,
        input  req1_valid_i, req1_ctrl_i, req1_a_i, req1_b_i,
        output req1_ready_o,
        output alu_ctrl_o, alu_src1_o, alu_src2_o,
        input  alu_result_i, alu_zero_i,
        output rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o, rsp_err_o,
        input  rsp_ready_i
    );

endinterface
`default_nettype wire

// File: rtl/alu_share_arb_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arb_rr_arb2
// Description : Two-input round-robin grant; ties go to the input not served last.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arb_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic       o_gnt_id,
    output logic       o_gnt_any
);

    logic r_last;

    always_comb begin
        o_gnt_any = |i_req;
        if (&i_req) begin
            o_gnt_id = ~r_last;
        end else begin
            o_gnt_id = i_req[1];
        end
    end

    // Reset value 1 makes requester 0 the winner of the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (i_update) begin
            r_last <= o_gnt_id;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arb
// Description : Shares one ALU between two requesters with a held response.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    alu_share_arb_if.slave bus
);

    localparam logic [2:0] C_CNT_INIT = 3'(LATENCY - 1);

    logic [1:0]       r_state;
    logic [2:0]       r_cnt;
    alu_ctrl_t        r_ctrl;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_id;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_err;

    logic             w_gnt_id;
    logic             w_gnt_any;
    logic             w_accept;
    alu_ctrl_t        w_sel_ctrl;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;

    alu_share_arb_rr_arb2 u_arb (
        .clk       (clk_i),
        .rst       (rst_i),
        .i_req     ({bus.req1_valid_i, bus.req0_valid_i}),
        .i_update  (w_accept),
        .o_gnt_id  (w_gnt_id),
        .o_gnt_any (w_gnt_any)
    );

    assign w_accept   = (r_state == C_IDLE) & w_gnt_any;
    assign w_sel_ctrl = w_gnt_id ? bus.req1_ctrl_i : bus.req0_ctrl_i;
    assign w_sel_a    = w_gnt_id ? bus.req1_a_i    : bus.req0_a_i;
    assign w_sel_b    = w_gnt_id ? bus.req1_b_i    : bus.req0_b_i;

    assign bus.req0_ready_o = w_accept & ~w_gnt_id & bus.req0_valid_i;
    assign bus.req1_ready_o = w_accept &  w_gnt_id & bus.req1_valid_i;

    assign bus.alu_ctrl_o   = r_ctrl;
    assign bus.alu_src1_o   = r_a;
    assign bus.alu_src2_o   = r_b;

    assign bus.rsp_valid_o  = (r_state == C_RESP);
    assign bus.rsp_id_o     = r_id;
    assign bus.rsp_result_o = r_result;
    assign bus.rsp_zero_o   = r_zero;
    assign bus.rsp_err_o    = r_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= C_IDLE;
            r_cnt    <= 3'd0;
            r_ctrl   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_id     <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    if (w_accept) begin
                        r_ctrl <= w_sel_ctrl;
                        r_a    <= w_sel_a;
                        r_b    <= w_sel_b;
                        r_id   <= w_gnt_id;
                        if (is_legal_ctrl(w_sel_ctrl)) begin
                            r_cnt   <= C_CNT_INIT;
                            r_state <= C_EXEC;
                        end else begin
                            // Illegal codes never touch the ALU
                            r_result <= '0;
                            r_zero   <= 1'b0;
                            r_err    <= 1'b1;
                            r_state  <= C_RESP;
                        end
                    end
                end
                C_EXEC: begin
                    if (r_cnt == 3'd0) begin
                        r_result <= bus.alu_result_i;
                        r_zero   <= bus.alu_zero_i;
                        r_err    <= 1'b0;
                        r_state  <= C_RESP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                C_RESP: begin
                    if (bus.rsp_ready_i) begin
                        r_state <= C_IDLE;
                    end
                end
                default: begin
                    r_state <= C_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arb
// Description : Checks two arbiter instances (LATENCY 1 and 4) against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Stimulus per instance
    logic        v0 [2];
    logic        v1 [2];
    logic [3:0]  c0 [2];
    logic [3:0]  c1 [2];
    logic [31:0] a0 [2];
    logic [31:0] b0 [2];
    logic [31:0] a1 [2];
    logic [31:0] b1 [2];
    logic        rspr [2];
    logic        am [2];
    logic [31:0] ramp = 32'h0;

    // Observed outputs per instance
    logic [1:0]  o_r0, o_r1, o_rv, o_id, o_zero, o_err, alu_z;
    logic [3:0]  o_ctrl [2];
    logic [31:0] o_s1 [2];
    logic [31:0] o_s2 [2];
    logic [31:0] o_res [2];
    logic [31:0] alu_res [2];

    function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0011: return a ^ b;
            4'b0110: return a - b;
            4'b0111: return 32'($signed(a) < $signed(b));
            4'b1001: return ~(a | b);
            4'b1011: return {b[15:0], 16'h0};
            4'b1110, 4'b1111: return $signed(a) >>> b[4:0];
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    for (genvar d = 0; d < 2; d++) begin : g_dut
        alu_share_arb_if #(.WIDTH(32)) bus ();
        assign bus.req0_valid_i = v0[d];
        assign bus.req0_ctrl_i  = c0[d];
        assign bus.req0_a_i     = a0[d];
        assign bus.req0_b_i     = b0[d];
        assign bus.req1_valid_i = v1[d];
        assign bus.req1_ctrl_i  = c1[d];
        assign bus.req1_a_i     = a1[d];
        assign bus.req1_b_i     = b1[d];
        assign bus.rsp_ready_i  = rspr[d];
        assign alu_res[d]       = am[d] ? ramp : alu_fn(bus.alu_ctrl_o, bus.alu_src1_o, bus.alu_src2_o);
        assign alu_z[d]         = (alu_res[d] == 32'h0);
        assign bus.alu_result_i = alu_res[d];
        assign bus.alu_zero_i   = alu_z[d];
        assign o_r0[d]   = bus.req0_ready_o;
        assign o_r1[d]   = bus.req1_ready_o;
        assign o_rv[d]   = bus.rsp_valid_o;
        assign o_id[d]   = bus.rsp_id_o;
        assign o_zero[d] = bus.rsp_zero_o;
        assign o_err[d]  = bus.rsp_err_o;
        assign o_ctrl[d] = bus.alu_ctrl_o;
        assign o_s1[d]   = bus.alu_src1_o;
        assign o_s2[d]   = bus.alu_src2_o;
        assign o_res[d]  = bus.rsp_result_o;

        alu_share_arb #(.WIDTH(32), .LATENCY(d == 0 ? 1 : 4)) u_dut (
            .clk_i (clk),
            .rst_i (rst),
            .bus   (bus)
        );
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Transaction-level model: busy counts EXEC cycles left, pend holds a response
    bit          m_busy [2];
    int          m_left [2];
    bit          m_pend [2];
    bit          m_last [2];
    bit          m_id   [2];
    logic [3:0]  m_ctrl [2];
    logic [31:0] m_a    [2];
    logic [31:0] m_b    [2];
    logic [31:0] m_res  [2];
    bit          m_zero [2];
    bit          m_err  [2];

    function automatic bit legal(input logic [3:0] c);
        return c inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110,
                         4'b0111, 4'b1001, 4'b1011, 4'b1110, 4'b1111};
    endfunction

    task automatic model_reset(input int d);
        m_busy[d] = 0; m_left[d] = 0; m_pend[d] = 0; m_last[d] = 1; m_id[d] = 0;
        m_ctrl[d] = 4'h0; m_a[d] = 32'h0; m_b[d] = 32'h0;
        m_res[d] = 32'h0; m_zero[d] = 0; m_err[d] = 0;
    endtask

    task automatic model_cycle(input int d);
        bit idle;
        bit g;
        idle = !m_busy[d] && !m_pend[d];
        g    = (v0[d] && v1[d]) ? !m_last[d] : v1[d];
        if (chk_en) begin
            check($sformatf("d%0d req0_ready", d), 64'(o_r0[d]), 64'(idle && v0[d] && !g));
            check($sformatf("d%0d req1_ready", d), 64'(o_r1[d]), 64'(idle && v1[d] && g));
            check($sformatf("d%0d rsp_valid", d), 64'(o_rv[d]), 64'(m_pend[d]));
            check($sformatf("d%0d alu_ctrl", d), 64'(o_ctrl[d]), 64'(m_ctrl[d]));
            check($sformatf("d%0d alu_src1", d), 64'(o_s1[d]), 64'(m_a[d]));
            check($sformatf("d%0d alu_src2", d), 64'(o_s2[d]), 64'(m_b[d]));
            if (m_pend[d]) begin
                check($sformatf("d%0d rsp_id", d), 64'(o_id[d]), 64'(m_id[d]));
                check($sformatf("d%0d rsp_result", d), 64'(o_res[d]), 64'(m_res[d]));
                check($sformatf("d%0d rsp_zero", d), 64'(o_zero[d]), 64'(m_zero[d]));
                check($sformatf("d%0d rsp_err", d), 64'(o_err[d]), 64'(m_err[d]));
            end
        end
        if (rst) begin
            model_reset(d);
        end else if (idle && (v0[d] || v1[d])) begin
            m_last[d] = g;
            m_id[d]   = g;
            m_ctrl[d] = g ? c1[d] : c0[d];
            m_a[d]    = g ? a1[d] : a0[d];
            m_b[d]    = g ? b1[d] : b0[d];
            if (legal(m_ctrl[d])) begin
                m_busy[d] = 1;
                m_left[d] = (d == 0) ? 1 : 4;
            end else begin
                m_pend[d] = 1; m_res[d] = 32'h0; m_zero[d] = 0; m_err[d] = 1;
            end
        end else if (m_busy[d]) begin
            if (m_left[d] == 1) begin
                m_busy[d] = 0; m_pend[d] = 1;
                m_res[d] = alu_res[d]; m_zero[d] = alu_z[d]; m_err[d] = 0;
            end else begin
                m_left[d] = m_left[d] - 1;
            end
        end else if (m_pend[d] && rspr[d]) begin
            m_pend[d] = 0;
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) model_cycle(d);
    end

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int d, input int n, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (((n == 0) ? o_r0[d] : o_r1[d]) === 1'b1) begin
                at = cyc;
                break;
            end
        end
        check($sformatf("d%0d ready%0d seen", d, n), 64'(at >= 0), 64'd1);
    endtask

    task automatic wait_any(input int d, output int g);
        int at;
        at = -1;
        g  = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((o_r0[d] | o_r1[d]) === 1'b1) begin
                at = cyc;
                g  = o_r1[d] ? 1 : 0;
                break;
            end
        end
        check($sformatf("d%0d grant seen", d), 64'(at >= 0), 64'd1);
    endtask

    task automatic wait_rsp(input int d, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_rv[d] === 1'b1) begin
                at = cyc;
                break;
            end
        end
        check($sformatf("d%0d rsp seen", d), 64'(at >= 0), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial forever begin
        @(posedge clk);
        #2;
        ramp = ramp + 32'h0101_0011;
    end

    initial begin
        int ta, tr, g;
        logic [31:0] exp_cap;
        for (int d = 0; d < 2; d++) begin
            v0[d] = 0; v1[d] = 0; c0[d] = 0; c1[d] = 0;
            a0[d] = 0; b0[d] = 0; a1[d] = 0; b1[d] = 0;
            rspr[d] = 1; am[d] = 0;
            model_reset(d);
        end
        rst = 1;
        next_edge();
        chk_en = 1;
        next_edge();
        next_edge();
        rst = 0;
        @(negedge clk);
        check("reset rsp_valid", 64'(o_rv), 64'd0);
        check("reset alu_ctrl", 64'(o_ctrl[0]), 64'd0);
        check("reset alu_src1", 64'(o_s1[1]), 64'd0);
        check("reset rsp_result", 64'(o_res[0]), 64'd0);
        check("reset rsp_err", 64'(o_err), 64'd0);
        next_edge();

        // Contention: SUB 9-9 vs OR F0|0F, grants alternate starting with req0
        v0[0] = 1; c0[0] = 4'b0110; a0[0] = 32'd9;    b0[0] = 32'd9;
        v1[0] = 1; c1[0] = 4'b0001; a1[0] = 32'hF0;   b1[0] = 32'h0F;
        for (int k = 0; k < 4; k++) begin
            wait_any(0, g);
            check($sformatf("contention grant %0d", k), 64'(g), 64'(k % 2));
            wait_rsp(0, tr);
            check($sformatf("contention id %0d", k), 64'(o_id[0]), 64'(k % 2));
            check($sformatf("contention result %0d", k), 64'(o_res[0]), (k % 2) ? 64'hFF : 64'h0);
            check($sformatf("contention zero %0d", k), 64'(o_zero[0]), (k % 2) ? 64'd0 : 64'd1);
        end
        next_edge();
        v0[0] = 0; v1[0] = 0;

        // Single ADD 5+7 on LATENCY=1
        v0[0] = 1; c0[0] = 4'b0010; a0[0] = 32'd5; b0[0] = 32'd7;
        wait_ready(0, 0, ta);
        next_edge();
        v0[0] = 0;
        wait_rsp(0, tr);
        check("single latency", 64'(tr - ta), 64'd2);
        check("single result", 64'(o_res[0]), 64'd12);
        check("single zero", 64'(o_zero[0]), 64'd0);
        check("single id", 64'(o_id[0]), 64'd0);
        check("single err", 64'(o_err[0]), 64'd0);
        next_edge();

        // Backpressure: last served was req0, so the tie goes to req1 (AND FF&0F)
        rspr[0] = 0;
        v0[0] = 1; c0[0] = 4'b0010; a0[0] = 32'd1;  b0[0] = 32'd2;
        v1[0] = 1; c1[0] = 4'b0000; a1[0] = 32'hFF; b1[0] = 32'h0F;
        wait_any(0, g);
        check("bp first grant", 64'(g), 64'd1);
        next_edge();
        v1[0] = 0;
        wait_rsp(0, tr);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp rsp_valid held", 64'(o_rv[0]), 64'd1);
            check("bp result held", 64'(o_res[0]), 64'h0F);
            check("bp id held", 64'(o_id[0]), 64'd1);
            check("bp no grant", 64'({o_r1[0], o_r0[0]}), 64'd0);
        end
        @(posedge clk);
        #1;
        rspr[0] = 1;
        @(negedge clk);
        check("bp release valid", 64'(o_rv[0]), 64'd1);
        @(negedge clk);
        check("bp idle after hs", 64'(o_rv[0]), 64'd0);
        check("bp req0 next", 64'(o_r0[0]), 64'd1);
        next_edge();
        v0[0] = 0;
        wait_rsp(0, tr);
        check("bp second result", 64'(o_res[0]), 64'd3);
        check("bp second id", 64'(o_id[0]), 64'd0);
        next_edge();

        // Illegal code 0100 from req1; ALU driven with a ramp that must not be sampled
        am[0] = 1;
        v1[0] = 1; c1[0] = 4'b0100; a1[0] = 32'd3; b1[0] = 32'd4;
        wait_ready(0, 1, ta);
        next_edge();
        v1[0] = 0;
        wait_rsp(0, tr);
        check("illegal latency", 64'(tr - ta), 64'd1);
        check("illegal err", 64'(o_err[0]), 64'd1);
        check("illegal result", 64'(o_res[0]), 64'd0);
        check("illegal zero", 64'(o_zero[0]), 64'd0);
        check("illegal id", 64'(o_id[0]), 64'd1);
        next_edge();
        am[0] = 0;

        // LATENCY=4: capture is the ramp value present in the 4th EXEC cycle
        am[1] = 1;
        v0[1] = 1; c0[1] = 4'b0010; a0[1] = 32'h100; b0[1] = 32'h200;
        wait_ready(1, 0, ta);
        next_edge();
        v0[1] = 0;
        tr = -1;
        exp_cap = 32'hX;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("lat4 src1 stable", 64'(o_s1[1]), 64'h100);
            check("lat4 src2 stable", 64'(o_s2[1]), 64'h200);
            if (cyc == ta + 4) exp_cap = ramp;
            if (o_rv[1] === 1'b1) begin
                tr = cyc;
                break;
            end
        end
        check("lat4 latency", 64'(tr - ta), 64'd5);
        check("lat4 captured", 64'(o_res[1]), 64'(exp_cap));
        next_edge();
        am[1] = 0;

        // Reset during EXEC aborts the op
        v0[1] = 1; c0[1] = 4'b0010; a0[1] = 32'd1; b0[1] = 32'd1;
        wait_ready(1, 0, ta);
        next_edge();
        v0[1] = 0;
        rst = 1;
        next_edge();
        rst = 0;
        @(negedge clk);
        check("rst rsp_valid", 64'(o_rv[1]), 64'd0);
        check("rst alu_ctrl", 64'(o_ctrl[1]), 64'd0);
        check("rst alu_src1", 64'(o_s1[1]), 64'd0);
        check("rst alu_src2", 64'(o_s2[1]), 64'd0);
        check("rst rsp_result", 64'(o_res[1]), 64'd0);
        repeat (8) begin
            @(negedge clk);
            check("rst no rsp", 64'(o_rv[1]), 64'd0);
        end
        next_edge();
        v0[1] = 1; c0[1] = 4'b0010; a0[1] = 32'd2;  b0[1] = 32'd3;
        v1[1] = 1; c1[1] = 4'b0001; a1[1] = 32'h1;  b1[1] = 32'h2;
        wait_any(1, g);
        check("rst tie grant", 64'(g), 64'd0);
        next_edge();
        v0[1] = 0; v1[1] = 0;
        wait_rsp(1, tr);
        check("rst first result", 64'(o_res[1]), 64'd5);
        next_edge();
        repeat (3) next_edge();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
